// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT acquisition path (fft_acq_ctrl, fft,
// fft_spi_out): the acquisition sequencer state encoding and the default
// frame geometry constants.
// -----------------------------------------------------------------------------
package fft_pkg;

    // Acquisition sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_ADC  = 3'd2,
        INSERT    = 3'd3,
        WAIT_FFT  = 3'd4,
        START_SPI = 3'd5,
        WAIT_SPI  = 3'd6
    } fft_acq_state_e;

    // Default frame geometry shared by the FFT datapath blocks
    localparam int FFT_N_POINTS     = 16;
    localparam int FFT_SAMPLE_W     = 8;
    localparam int FFT_IN_W_DEFAULT = 16;

endpackage

// File: rtl/fft_frame_timer.sv
// -----------------------------------------------------------------------------
// fft_frame_timer
// Free-running frame period counter with periodic trigger tick.
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : 1 = counter runs; 0 = counter held at 0
//   continuous  : 1 = tick generation allowed
//   tick        : high for the cycle in which the counter sits at
//                 FRAME_PERIOD-1 (while enable & continuous)
// -----------------------------------------------------------------------------
module fft_frame_timer #(
    parameter int FRAME_PERIOD = 262144
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic continuous,
    output logic tick
);

    localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: hold at zero while disabled, wrap at the end of the period
    always_comb begin
        count_d = count_q;
        if (!enable) begin
            count_d = '0;
        end else if (count_q == LAST_CNT) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Period counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = enable & continuous & (count_q == LAST_CNT);

endmodule

// File: rtl/fft_acq_ctrl.sv
// -----------------------------------------------------------------------------
// fft_acq_ctrl
// Acquisition/frame sequencer for the FFT datapath. A trigger (periodic tick
// or sw_start) starts a frame: each sample is requested from the ADC, packed
// into an FFT input word and written by address; once the frame is written
// the block waits for fft_finish, launches the SPI result dump and counts the
// completed frame. Triggers arriving mid-frame are dropped and flagged.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   enable, continuous      trigger enable, periodic trigger mode
//   sw_start                software trigger pulse
//   adc_sample/valid/data   ADC conversion request / result handshake
//   fft_insert/addr/imag/data  FFT sample write port
//   fft_finish              FFT done pulse
//   spi_start, spi_busy     SPI result dump handshake
//   busy, overrun, frame_cnt   status
//
// Build option: define FFT_ACQ_COMPLEX_EN to take two samples per address
// (real part then imaginary part, the latter shifted up by SAMPLE_W).
// -----------------------------------------------------------------------------
module fft_acq_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS     = FFT_N_POINTS,
    parameter int ADDR_W       = 4,
    parameter int SAMPLE_W     = FFT_SAMPLE_W,
    parameter int FFT_IN_W     = FFT_IN_W_DEFAULT,
    parameter int FRAME_PERIOD = 262144,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   continuous,
    input  logic                   sw_start,
    output logic                   adc_sample,
    input  logic                   adc_valid,
    input  logic [SAMPLE_W-1:0]    adc_data,
    output logic                   fft_insert,
    output logic [ADDR_W-1:0]      fft_addr,
    output logic                   fft_imag,
    output logic [FFT_IN_W-1:0]    fft_data,
    input  logic                   fft_finish,
    output logic                   spi_start,
    input  logic                   spi_busy,
    output logic                   busy,
    output logic                   overrun,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

`ifdef FFT_ACQ_COMPLEX_EN
    localparam bit COMPLEX_EN = 1'b1;
`else
    localparam bit COMPLEX_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);

    fft_acq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   imag_q, imag_d;
    logic [FFT_IN_W-1:0]    data_q, data_d;
    logic                   adc_sample_q, adc_sample_d;
    logic                   fft_insert_q, fft_insert_d;
    logic                   spi_start_q, spi_start_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                   tick_s;
    logic                   trigger_s;
    logic [FFT_IN_W-1:0]    sample_ext_s;

    fft_frame_timer #(
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_frame_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .continuous (continuous),
        .tick       (tick_s)
    );

    // A tick coinciding with sw_start is a single trigger
    assign trigger_s    = tick_s | (enable & sw_start);
    assign sample_ext_s = {{(FFT_IN_W - SAMPLE_W){1'b0}}, adc_data};

    // Next-state, datapath and strobe logic; strobes are computed one cycle
    // ahead so they are registered and line up with the state they belong to
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        imag_d       = imag_q;
        data_d       = data_q;
        adc_sample_d = 1'b0;
        fft_insert_d = 1'b0;
        spi_start_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        if (trigger_s && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    state_d      = REQ;
                    addr_d       = '0;
                    imag_d       = 1'b0;
                    adc_sample_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = WAIT_ADC;
            end
            WAIT_ADC: begin
                if (adc_valid) begin
                    if (imag_q) begin
                        data_d = sample_ext_s << SAMPLE_W;
                    end else begin
                        data_d = sample_ext_s;
                    end
                    fft_insert_d = 1'b1;
                    state_d      = INSERT;
                end else begin
                    state_d = WAIT_ADC;
                end
            end
            INSERT: begin
                if (COMPLEX_EN && !imag_q) begin
                    // imaginary half of the same address still to come
                    imag_d       = 1'b1;
                    state_d      = REQ;
                    adc_sample_d = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = WAIT_FFT;
                end else begin
                    addr_d       = addr_q + ADDR_W'(1);
                    imag_d       = 1'b0;
                    state_d      = REQ;
                    adc_sample_d = 1'b1;
                end
            end
            WAIT_FFT: begin
                if (fft_finish) begin
                    state_d     = START_SPI;
                    spi_start_d = 1'b1;
                end else begin
                    state_d = WAIT_FFT;
                end
            end
            START_SPI: begin
                state_d = WAIT_SPI;
            end
            WAIT_SPI: begin
                if (!spi_busy) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end else begin
                    state_d = WAIT_SPI;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            imag_q       <= 1'b0;
            data_q       <= '0;
            adc_sample_q <= 1'b0;
            fft_insert_q <= 1'b0;
            spi_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            imag_q       <= imag_d;
            data_q       <= data_d;
            adc_sample_q <= adc_sample_d;
            fft_insert_q <= fft_insert_d;
            spi_start_q  <= spi_start_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign adc_sample = adc_sample_q;
    assign fft_insert = fft_insert_q;
    assign fft_addr   = addr_q;
    assign fft_imag   = imag_q;
    assign fft_data   = data_q;
    assign spi_start  = spi_start_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_acq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_acq_ctrl
// Self-checking bench for fft_acq_ctrl. The bench plays the ADC, FFT and SPI
// peers; expected FFT writes are derived from the frame rules (sample k goes
// to address k/S, part k%S, shifted by SAMPLE_W for the imaginary part).
// -----------------------------------------------------------------------------
module tb_fft_acq_ctrl;

    localparam int N   = 16;
    localparam int AW  = 4;
    localparam int SW  = 8;
    localparam int IW  = 16;
    localparam int FCW = 16;
`ifdef FFT_ACQ_COMPLEX_EN
    localparam int SPW    = 2;
    localparam int PERIOD = 128;
`else
    localparam int SPW    = 1;
    localparam int PERIOD = 64;
`endif

    logic           clk = 1'b0;
    logic           rst_n, enable, continuous, sw_start;
    logic           adc_sample, adc_valid;
    logic [SW-1:0]  adc_data;
    logic           fft_insert, fft_imag, fft_finish;
    logic [AW-1:0]  fft_addr;
    logic [IW-1:0]  fft_data;
    logic           spi_start, spi_busy, busy, overrun;
    logic [FCW-1:0] frame_cnt;

    int   n_checks = 0;
    int   n_err    = 0;
    int   exp_frames = 0;
    logic exp_ovr  = 1'b0;
    int   cyc      = 0;

    fft_acq_ctrl #(
        .N_POINTS(N), .ADDR_W(AW), .SAMPLE_W(SW), .FFT_IN_W(IW),
        .FRAME_PERIOD(PERIOD), .FRAME_CNT_W(FCW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .continuous(continuous),
        .sw_start(sw_start), .adc_sample(adc_sample), .adc_valid(adc_valid),
        .adc_data(adc_data), .fft_insert(fft_insert), .fft_addr(fft_addr),
        .fft_imag(fft_imag), .fft_data(fft_data), .fft_finish(fft_finish),
        .spi_start(spi_start), .spi_busy(spi_busy), .busy(busy),
        .overrun(overrun), .frame_cnt(frame_cnt)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobes"}, {29'd0, adc_sample, fft_insert, spi_start}, 32'd0);
        check_eq({tag, "_addr"}, 32'(fft_addr), 32'd0);
        check_eq({tag, "_imag"}, 32'(fft_imag), 32'd0);
        check_eq({tag, "_data"}, 32'(fft_data), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
        check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
    endtask

    // Software trigger; the conversion request must follow one cycle later
    task automatic sw_trigger();
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        check_eq("trig_latency", 32'(adc_sample), 32'd1);
    endtask

    // Serve one frame. pat: 0 addr+1, 1 alternating 0x12/0x34, 2 random,
    // 3 random with zero ADC/FFT/SPI delays. abort_k >= 0 resets the DUT when
    // sample abort_k is requested.
    task automatic run_frame(input int pat, input int abort_k, input bit stray,
                             input bit ovr_poke, output int start_cyc);
        int          t, d, w, nb;
        logic [7:0]  smp;
        logic [15:0] e;
        bit          bad;
        start_cyc = -1;
        for (int k = 0; k < N * SPW; k++) begin
            t = 0;
            while (!adc_sample && t < 3 * PERIOD) begin
                @(negedge clk);
                t++;
            end
            check_eq("req_seen", 32'(adc_sample), 32'd1);
            if (!adc_sample) return;
            if (k == 0) start_cyc = cyc;
            if (k == abort_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                exp_frames = 0;
                exp_ovr    = 1'b0;
                check_all_zero("abort");
                bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (spi_start || busy || adc_sample || fft_insert) bad = 1'b1;
                end
                check_eq("abort_quiet", 32'(bad), 32'd0);
                return;
            end
            case (pat)
                0:       smp = 8'(k / SPW + 1);
                1:       smp = (k % 2 == 0) ? 8'h12 : 8'h34;
                default: smp = 8'($urandom_range(0, 255));
            endcase
            d = (pat == 3) ? 0 : int'($urandom_range(0, 3));
            if (stray && k == 3 && d == 0) d = 1;
            @(negedge clk);
            check_eq("req_pulse", 32'(adc_sample), 32'd0);
            for (int j = 0; j < d; j++) begin
                fft_finish = (stray && k == 3 && j == 0);
                @(negedge clk);
                fft_finish = 1'b0;
            end
            adc_data  = smp;
            adc_valid = 1'b1;
            @(negedge clk);
            adc_valid = 1'b0;
            adc_data  = 8'($urandom_range(0, 255));
            e = {8'h00, smp};
            if (k % SPW == 1) e = e << SW;
            check_eq("ins_strobe", 32'(fft_insert), 32'd1);
            check_eq("ins_addr", 32'(fft_addr), 32'(k / SPW));
            check_eq("ins_imag", 32'(fft_imag), 32'(k % SPW));
            check_eq("ins_data", 32'(fft_data), 32'(e));
            @(negedge clk);
            check_eq("ins_pulse", 32'(fft_insert), 32'd0);
            check_eq("data_hold", 32'(fft_data), 32'(e));
        end
        // frame written: FFT is busy
        if (ovr_poke) begin
            sw_start = 1'b1;
            @(negedge clk);
            sw_start = 1'b0;
            exp_ovr = 1'b1;
            check_eq("ovr_set", 32'(overrun), 32'd1);
        end
        w   = (pat == 3) ? 0 : int'($urandom_range(1, 5));
        bad = 1'b0;
        repeat (w) begin
            if (adc_sample || !busy || spi_start || fft_insert) bad = 1'b1;
            @(negedge clk);
        end
        check_eq("wait_fft_quiet", 32'(bad), 32'd0);
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        check_eq("spi_start", 32'(spi_start), 32'd1);
        spi_busy = (pat != 3);
        nb = int'($urandom_range(1, 4));
        @(negedge clk);
        check_eq("spi_pulse", 32'(spi_start), 32'd0);
        if (spi_busy) repeat (nb) @(negedge clk);
        spi_busy = 1'b0;
        t = 0;
        while (busy && t < 10) begin
            @(negedge clk);
            t++;
        end
        exp_frames++;
        check_eq("frame_done", 32'(busy), 32'd0);
        check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check_eq("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int st, base;
        bit bad;
        rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; sw_start = 1'b0;
        adc_valid = 1'b0; adc_data = '0; fft_finish = 1'b0; spi_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("reset");

        // stray adc_valid / fft_finish while idle
        enable = 1'b1;
        adc_valid = 1'b1; fft_finish = 1'b1; adc_data = 8'hA5;
        @(negedge clk);
        adc_valid = 1'b0; fft_finish = 1'b0;
        @(negedge clk);
        check_all_zero("stray_idle");

        // disabled: sw_start ignored
        enable = 1'b0;
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        @(negedge clk);
        check_eq("disabled_busy", {30'd0, busy, adc_sample}, 32'd0);
        enable = 1'b1;

        // directed pattern frame with stray fft_finish in WAIT_ADC
        sw_trigger();
        run_frame((SPW == 2) ? 1 : 0, -1, 1'b1, 1'b0, st);
        // overrun: sw_start while waiting for the FFT
        sw_trigger();
        run_frame(2, -1, 1'b0, 1'b1, st);
        // reset mid-frame at address 7
        sw_trigger();
        run_frame(2, 7 * SPW, 1'b0, 1'b0, st);
        // random frames
        repeat (2) begin
            sw_trigger();
            run_frame(2, -1, 1'b0, 1'b0, st);
        end

        // continuous mode: a frame every PERIOD cycles from enable rising
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        continuous = 1'b1;
        base = cyc;
        for (int f = 0; f < 3; f++) begin
            run_frame(3, -1, 1'b0, 1'b0, st);
            check_eq("cont_start", 32'(st - base), 32'(PERIOD * (f + 1)));
        end
        continuous = 1'b0;
        enable     = 1'b0;
        bad = 1'b0;
        repeat (PERIOD + 4) begin
            @(negedge clk);
            if (adc_sample || busy) bad = 1'b1;
        end
        check_eq("cont_stopped", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
